// File: rtl/vend_pkg.sv
// Shared types for the vending dispense arbiter: product codes, one-hot motor
// selects, FSM state encoding and the code-to-select helper.
package vend_pkg;

   typedef enum logic [1:0] {
      PROD_COKE    = 2'd0,
      PROD_PEPSI   = 2'd1,
      PROD_SPRITE  = 2'd2,
      PROD_INVALID = 2'd3
   } prod_e;

   localparam logic [3:0] DISP_NONE   = 4'b0000;
   localparam logic [3:0] DISP_COKE   = 4'b0001;
   localparam logic [3:0] DISP_PEPSI  = 4'b0010;
   localparam logic [3:0] DISP_SPRITE = 4'b0100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_COOL = 2'd2
   } state_e;

   function automatic logic [3:0] prod_to_onehot(input logic [1:0] code);
      case (code)
         PROD_COKE:   return DISP_COKE;
         PROD_PEPSI:  return DISP_PEPSI;
         PROD_SPRITE: return DISP_SPRITE;
         default:     return DISP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around the NUM_REQ panels.
module vend_rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   logic found;

   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
            grant_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            found     = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Shares one dispense motor among NUM_REQ panels: round-robin grant, timed motor
// pulse, per-product stock. Stock tracking is built only with VEND_STOCK_EN.
module vend_dispense_arbiter
   import vend_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int MOTOR_CYCLES = 8,
   parameter int STOCK_W      = 4,
   parameter int STOCK_INIT   = 15,
   parameter int STOCK_MAX    = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [2*NUM_REQ-1:0]   req_prod,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     req_fail,
   output logic                   motor_en,
   output logic [3:0]             motor_sel,
   output logic                   busy,
   input  logic                   restock,
   input  logic [1:0]             restock_prod,
   output logic [2:0]             sold_out
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;

   state_e             state, state_next;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [NUM_REQ-1:0] ack_next, fail_next;
   logic               motor_en_next, busy_next;
   logic [3:0]         sel_next;
   logic [IDX_W-1:0]   grant_idx;
   logic               any_req;
   logic [1:0]         win_code;
   logic               have_stock;
   logic               grant;

   vend_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   assign win_code = req_prod[int'(grant_idx)*2 +: 2];
   assign grant    = (state == ST_IDLE) && any_req && have_stock;

`ifdef VEND_STOCK_EN
   logic [STOCK_W-1:0] stock      [3];
   logic [STOCK_W-1:0] stock_next [3];

   always_comb begin
      have_stock = 1'b0;
      for (int p = 0; p < 3; p++) begin
         if (win_code == 2'(p) && stock[p] != '0) have_stock = 1'b1;
      end
   end

   // A restock landing on the same edge as a grant of that product wins, minus the vend.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         stock_next[p] = stock[p];
         if (restock && restock_prod == 2'(p)) stock_next[p] = STOCK_W'(STOCK_MAX);
         if (grant && win_code == 2'(p)) begin
            if (restock && restock_prod == 2'(p)) stock_next[p] = STOCK_W'(STOCK_MAX - 1);
            else                                  stock_next[p] = stock[p] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 3; p++) stock[p] <= STOCK_W'(STOCK_INIT);
      end else begin
         for (int p = 0; p < 3; p++) stock[p] <= stock_next[p];
      end
   end

   always_comb begin
      for (int p = 0; p < 3; p++) sold_out[p] = (stock[p] == '0);
   end
`else
   logic unused_restock;

   assign unused_restock = ^{restock, restock_prod};
   assign have_stock     = (win_code != PROD_INVALID);
   assign sold_out       = 3'b000;
`endif

   always_comb begin
      state_next    = state;
      rr_ptr_next   = rr_ptr;
      cnt_next      = cnt;
      ack_next      = '0;
      fail_next     = '0;
      motor_en_next = motor_en;
      sel_next      = motor_sel;
      busy_next     = busy;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
               if (have_stock) begin
                  ack_next[grant_idx] = 1'b1;
                  motor_en_next       = 1'b1;
                  sel_next            = prod_to_onehot(win_code);
                  busy_next           = 1'b1;
                  cnt_next            = CNT_W'(MOTOR_CYCLES - 1);
                  state_next          = ST_RUN;
               end else begin
                  fail_next[grant_idx] = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (cnt == '0) begin
               motor_en_next = 1'b0;
               sel_next      = DISP_NONE;
               state_next    = ST_COOL;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         ST_COOL: begin
            busy_next  = 1'b0;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         cnt       <= '0;
         req_ack   <= '0;
         req_fail  <= '0;
         motor_en  <= 1'b0;
         motor_sel <= DISP_NONE;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         rr_ptr    <= rr_ptr_next;
         cnt       <= cnt_next;
         req_ack   <= ack_next;
         req_fail  <= fail_next;
         motor_en  <= motor_en_next;
         motor_sel <= sel_next;
         busy      <= busy_next;
      end
   end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench for vend_dispense_arbiter (NUM_REQ=2, MOTOR_CYCLES=4, STOCK_INIT=1).
// Stock-dependent expectations follow VEND_STOCK_EN.
module tb_vend_dispense_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req_valid;
   logic [3:0] req_prod;
   logic [1:0] req_ack;
   logic [1:0] req_fail;
   logic       motor_en;
   logic [3:0] motor_sel;
   logic       busy;
   logic       restock;
   logic [1:0] restock_prod;
   logic [2:0] sold_out;

   int vector_count = 0;
   int miscompares  = 0;

   vend_dispense_arbiter #(
      .NUM_REQ(2), .MOTOR_CYCLES(4), .STOCK_W(4), .STOCK_INIT(1), .STOCK_MAX(15)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_prod     (req_prod),
      .req_ack      (req_ack),
      .req_fail     (req_fail),
      .motor_en     (motor_en),
      .motor_sel    (motor_sel),
      .busy         (busy),
      .restock      (restock),
      .restock_prod (restock_prod),
      .sold_out     (sold_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      vector_count++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      checkOutput({tag, "_idle"}, 32'(busy), 32'(0));
   endtask

   // One request vector: drive, check the pulse one edge later, release, wait for idle.
   task automatic applyStimulus(input string tag, input logic [1:0] mask, input logic [3:0] prods,
                                input logic [1:0] exp_ack, input logic [1:0] exp_fail,
                                input logic [3:0] exp_sel);
      req_valid = mask;
      req_prod  = prods;
      tick();
      checkOutput({tag, "_ack"},  32'(req_ack),   32'(exp_ack));
      checkOutput({tag, "_fail"}, 32'(req_fail),  32'(exp_fail));
      checkOutput({tag, "_en"},   32'(motor_en),  32'(|exp_ack));
      checkOutput({tag, "_sel"},  32'(motor_sel), 32'(exp_sel));
      req_valid = 2'b00;
      waitIdle(tag);
   endtask

   initial begin
      int en_cycles, busy_cycles, gap;
      logic [1:0] ack_after;

      reset = 1'b1; req_valid = 2'b00; req_prod = 4'h0; restock = 1'b0; restock_prod = 2'd0;
      tick(); tick();
      reset = 1'b0;
      tick();
      checkOutput("rst_ack",  32'(req_ack),   32'(0));
      checkOutput("rst_fail", 32'(req_fail),  32'(0));
      checkOutput("rst_en",   32'(motor_en),  32'(0));
      checkOutput("rst_sel",  32'(motor_sel), 32'(0));
      checkOutput("rst_busy", 32'(busy),      32'(0));
      checkOutput("rst_sold", 32'(sold_out),  32'(0));

      // Single pepsi vend from panel 0 with pulse-width checks.
      req_valid = 2'b01; req_prod = 4'b0001;
      tick();
      checkOutput("t1_ack",  32'(req_ack),   32'(2'b01));
      checkOutput("t1_sel",  32'(motor_sel), 32'(4'b0010));
      checkOutput("t1_busy", 32'(busy),      32'(1));
      req_valid = 2'b00;
      en_cycles = 1; busy_cycles = 1; ack_after = 2'b11;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 0) ack_after = req_ack;
         if (!busy) break;
         busy_cycles++;
         if (motor_en) en_cycles++;
      end
      checkOutput("t1_ackpulse", 32'(ack_after),   32'(0));
      checkOutput("t1_en_len",   32'(en_cycles),   32'(4));
      checkOutput("t1_busy_len", 32'(busy_cycles), 32'(5));
      checkOutput("t1_sel_off",  32'(motor_sel),   32'(0));
`ifdef VEND_STOCK_EN
      checkOutput("t1_sold", 32'(sold_out), 32'(3'b010));
      applyStimulus("t3_soldout", 2'b01, 4'b0001, 2'b00, 2'b01, 4'b0000);
`else
      checkOutput("t1_sold", 32'(sold_out), 32'(3'b000));
      applyStimulus("t3_again", 2'b01, 4'b0001, 2'b01, 2'b00, 4'b0010);
`endif

      // Contention with rr_ptr=1: panel 1 (sprite) first, panel 0 (coke) six cycles later.
      req_valid = 2'b11; req_prod = 4'b1000;
      tick();
      checkOutput("t2_ack1", 32'(req_ack),   32'(2'b10));
      checkOutput("t2_sel1", 32'(motor_sel), 32'(4'b0100));
      req_valid = 2'b01;
      gap = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         gap++;
         if (req_ack != 2'b00) break;
      end
      checkOutput("t2_gap",  32'(gap),       32'(6));
      checkOutput("t2_ack0", 32'(req_ack),   32'(2'b01));
      checkOutput("t2_sel0", 32'(motor_sel), 32'(4'b0001));
      req_valid = 2'b00;
      waitIdle("t2");

      // Invalid code from panel 1 is rejected in both builds.
      applyStimulus("code3", 2'b10, 4'b1100, 2'b00, 2'b10, 4'b0000);

`ifdef VEND_STOCK_EN
      checkOutput("t2_sold", 32'(sold_out), 32'(3'b111));
      restock = 1'b1; restock_prod = 2'd0;
      tick();
      restock = 1'b0;
      checkOutput("rs_sold", 32'(sold_out), 32'(3'b110));
      // Grant and restock of coke on one edge leave 14: 14 more vends succeed, the next fails.
      req_valid = 2'b01; req_prod = 4'b0000; restock = 1'b1; restock_prod = 2'd0;
      tick();
      restock = 1'b0;
      checkOutput("t4_ack", 32'(req_ack), 32'(2'b01));
      req_valid = 2'b00;
      waitIdle("t4");
      for (int i = 0; i < 14; i++) applyStimulus("t4_drain", 2'b01, 4'b0000, 2'b01, 2'b00, 4'b0001);
      applyStimulus("t4_empty", 2'b01, 4'b0000, 2'b00, 2'b01, 4'b0000);
      checkOutput("t4_sold", 32'(sold_out), 32'(3'b111));
      restock = 1'b1; restock_prod = 2'd1;
      tick();
      restock = 1'b0;
      checkOutput("rs1_sold", 32'(sold_out), 32'(3'b101));
`else
      for (int i = 0; i < 3; i++) applyStimulus("t6_pepsi", 2'b01, 4'b0001, 2'b01, 2'b00, 4'b0010);
      checkOutput("t6_sold", 32'(sold_out), 32'(3'b000));
`endif

      // Reset during RUN drops the motor without waiting for a clock edge.
      req_valid = 2'b01; req_prod = 4'b0001;
      tick();
      checkOutput("t5_ack", 32'(req_ack), 32'(2'b01));
      req_valid = 2'b00;
      tick();
      checkOutput("t5_run_en", 32'(motor_en), 32'(1));
      #2 reset = 1'b1;
      #1;
      checkOutput("t5_async_en",   32'(motor_en),  32'(0));
      checkOutput("t5_async_busy", 32'(busy),      32'(0));
      checkOutput("t5_async_sel",  32'(motor_sel), 32'(0));
      tick();
      reset = 1'b0;
      tick();
      checkOutput("t5_busy", 32'(busy),     32'(0));
      checkOutput("t5_sold", 32'(sold_out), 32'(0));
      // rr_ptr was 1 before reset; after reset panel 0 must win again.
      applyStimulus("t5_ptr", 2'b11, 4'b0100, 2'b01, 2'b00, 4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompares);
      $finish;
   end

endmodule
